pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock, clk (input, 1): all state updates on rising edge.
REQ-002 SHALL have rst (input, 1): reset is synchronous and active-high.
REQ-003 SHALL have id_rs1, id_rs2 (input, 5 each): source register indices of the instruction in ID.
REQ-004 SHALL have id_use_rs1, id_use_rs2 (input, 1 each): ID instruction actually reads rs1/rs2.
REQ-005 SHALL have ex_rd (input, 5) and ex_is_load (input, 1): destination register and load flag of the instruction in EX.
REQ-006 SHALL have ex_jb (input, 1): jump or taken branch resolved in EX.
REQ-007 SHALL have icache_miss and dcache_miss (input, 1 each): level-high while a fetch or data miss is outstanding.
REQ-008 SHALL have icache_done and dcache_done (input, 1 each): single-cycle refill-complete pulses.
REQ-009 SHALL have stall (output, 1): load-use bubble request to pipeline registers.
REQ-010 SHALL have jb (output, 1): flush request to IF/ID and ID/EX registers.
REQ-011 SHALL have stall_cache (output, 1): hold-all request to every pipeline register.
REQ-012 SHALL have pc_write (output, 1): PC update enable.
REQ-013 SHALL have stall_cycles (output, 32): stall performance count.

Function
REQ-014 SHALL implement FSM states IDLE, DSTALL and ISTALL, with stall_cache = 1 in DSTALL and ISTALL.
REQ-015 SHALL make these transitions from IDLE: dcache_miss -> DSTALL; else icache_miss -> ISTALL; otherwise remain in IDLE.
REQ-016 SHALL leave DSTALL on dcache_done: to ISTALL if icache_miss is high, else to IDLE.
REQ-017 SHALL leave ISTALL on icache_done: to DSTALL if dcache_miss is high, else to IDLE.
REQ-018 SHALL also assert stall_cache combinationally in IDLE whenever icache_miss or dcache_miss is high, so the hold begins in the miss cycle.
REQ-019 SHALL hold stall_cache high in the cycle the done pulse is sampled and deassert it the next cycle when the FSM returns to IDLE.
REQ-020 SHALL ignore done pulses that do not match the current state.
REQ-021 SHALL assert stall = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-022 SHALL force stall = 0 whenever stall_cache or jb is 1.
REQ-023 SHALL keep a pending-flush flag jb_pend, set when ex_jb = 1 while stall_cache = 1.
REQ-024 SHALL drive jb = (ex_jb | jb_pend) & ~stall_cache.
REQ-025 SHALL clear jb_pend in the cycle jb is emitted, giving exactly one flush per resolved branch.
REQ-026 SHALL drive pc_write = ~(stall | stall_cache); when jb = 1, pc_write SHALL be 1 so the target PC loads.
REQ-027 SHALL have no latency other than the stated FSM and jb_pend registering; all other outputs are combinational from inputs and state.

Reset
REQ-028 SHALL, on rst = 1 at a rising edge, set FSM = IDLE, jb_pend = 0 and stall_cycles = 0, including mid-miss; rst has priority over all events.
REQ-029 SHALL hold outputs during reset at stall = 0, jb = 0, stall_cache = 0, pc_write = 1.

Configuration
REQ-030 SHALL, when PIPE_HAZARD_CTRL_PERF_EN is defined, count each non-reset cycle with stall | stall_cache into stall_cycles, saturating at 32'hFFFF_FFFF without wrap.
REQ-031 SHALL, when PIPE_HAZARD_CTRL_PERF_EN is undefined, tie stall_cycles to 0 and remove the counter logic.

Verification
REQ-032 SHALL cover load-use: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> stall = 1, pc_write = 0 that cycle; with ex_rd = 0 -> stall = 0.
REQ-033 SHALL cover a data miss: dcache_miss high for 4 cycles, then dcache_done -> stall_cache = 1 for 5 cycles (miss cycle through done cycle), FSM back to IDLE, stall_cycles = 5 with PERF_EN.
REQ-034 SHALL cover simultaneous misses: icache_miss and dcache_miss rise together -> DSTALL, then on dcache_done ISTALL, then on icache_done IDLE; stall_cache high throughout.
REQ-035 SHALL cover a branch during a miss: ex_jb = 1 in the second DSTALL cycle, then dropped -> jb = 0 during the stall and jb = 1 for exactly one cycle after return to IDLE.
REQ-036 SHALL cover reset mid-miss: rst pulsed in ISTALL with jb_pend = 1 -> next cycle FSM = IDLE, jb = 0, stall_cache = 0 (misses low), stall_cycles = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller.
//   - load-use bubble detection (stall)
//   - jump/branch flush with a pending flag so a branch resolved during a cache
//     hold is flushed exactly once after the hold ends (jb)
//   - cache-miss hold sequencing for data and instruction refills (stall_cache)
//   - optional stall performance counter, enabled by defining
//     PIPE_HAZARD_CTRL_PERF_EN (stall_cycles reads 0 when it is not defined)
//
// state  | meaning
// IDLE   | no refill in progress; a raised miss level starts the hold at once
// DSTALL | data refill outstanding, waiting for dcache_done
// ISTALL | instruction refill outstanding, waiting for icache_done
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_jb,
   input  logic        icache_miss,
   input  logic        dcache_miss,
   input  logic        icache_done,
   input  logic        dcache_done,
   output logic        stall,
   output logic        jb,
   output logic        stall_cache,
   output logic        pc_write,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DSTALL = 2'd1,
      ISTALL = 2'd2
   } state_t;

   state_t state;
   logic   jb_pend;
   logic   load_use;

   // Refill sequencing; a data miss wins when both misses are seen in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (dcache_miss)      state <= DSTALL;
               else if (icache_miss) state <= ISTALL;
            end
            DSTALL: begin
               if (dcache_done)      state <= icache_miss ? ISTALL : IDLE;
            end
            ISTALL: begin
               if (icache_done)      state <= dcache_miss ? DSTALL : IDLE;
            end
            default:                 state <= IDLE;
         endcase
      end
   end

   // Remember a branch that resolved while the pipeline was held; drop it once flushed.
   always_ff @(posedge clk) begin
      if (rst)                        jb_pend <= 1'b0;
      else if (ex_jb && stall_cache)  jb_pend <= 1'b1;
      else if (jb)                    jb_pend <= 1'b0;
   end

   // Hazard outputs; reset forces the quiet values so nothing is held or flushed.
   always_comb begin
      load_use = ex_is_load && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
      stall_cache = !rst && ((state != IDLE) || icache_miss || dcache_miss);
      jb          = !rst && (ex_jb || jb_pend) && !stall_cache;
      stall       = !rst && load_use && !stall_cache && !jb;
      pc_write    = !(stall || stall_cache);
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt;

   // Count held cycles, sticking at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst)                                        stall_cnt <= 32'd0;
      else if ((stall || stall_cache) && (stall_cnt != 32'hFFFF_FFFF))
                                                      stall_cnt <= stall_cnt + 32'd1;
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written miss/branch/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_is_load, ex_jb;
   logic        icache_miss, dcache_miss, icache_done, dcache_done;
   logic        stall, jb, stall_cache, pc_write;
   logic [31:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_jb(ex_jb),
      .icache_miss(icache_miss), .dcache_miss(dcache_miss),
      .icache_done(icache_done), .dcache_done(dcache_done),
      .stall(stall), .jb(jb), .stall_cache(stall_cache),
      .pc_write(pc_write), .stall_cycles(stall_cycles)
   );

   // ---------------- reference model ----------------
   // srv holds the refill currently being waited on ('D' or 'I'); empty = none.
   localparam byte K_D = 8'h44;
   localparam byte K_I = 8'h49;
   byte    srv[$];
   bit     m_pend = 1'b0;
   longint m_cnt  = 0;

   bit e_stall, e_jb, e_sc, e_pcw;
   bit s_stall, s_jb, s_sc, s_pcw;
   logic [31:0] s_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      return 32'(m_cnt);
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_outputs();
      bit lu;
      lu = ex_is_load && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (rst) begin
         e_sc = 0; e_jb = 0; e_stall = 0; e_pcw = 1;
      end else begin
         e_sc    = (srv.size() > 0) || icache_miss || dcache_miss;
         e_jb    = (ex_jb || m_pend) && !e_sc;
         e_stall = lu && !e_sc && !e_jb;
         e_pcw   = !(e_stall || e_sc);
      end
   endtask

   task automatic model_edge();
      model_outputs();
      if (rst) begin
         srv.delete();
         m_pend = 0;
         m_cnt  = 0;
      end else begin
         if ((e_stall || e_sc) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (ex_jb && e_sc) m_pend = 1;
         else if (e_jb)     m_pend = 0;
         if (srv.size() == 0) begin
            if (dcache_miss)      srv.push_back(K_D);
            else if (icache_miss) srv.push_back(K_I);
         end else if (srv[0] == K_D && dcache_done) begin
            void'(srv.pop_front());
            if (icache_miss) srv.push_back(K_I);
         end else if (srv[0] == K_I && icache_done) begin
            void'(srv.pop_front());
            if (dcache_miss) srv.push_back(K_D);
         end
      end
   endtask

   // Called 2 time units after a rising edge with inputs already set: settle,
   // compare against the model, snapshot outputs, cross the next edge.
   task automatic cyc();
      #5;
      model_outputs();
      chk("model_stall",       32'(stall),       32'(e_stall));
      chk("model_jb",          32'(jb),          32'(e_jb));
      chk("model_stall_cache", 32'(stall_cache), 32'(e_sc));
      chk("model_pc_write",    32'(pc_write),    32'(e_pcw));
      chk("model_stall_cycles", stall_cycles,    exp_cnt());
      s_stall = stall; s_jb = jb; s_sc = stall_cache; s_pcw = pc_write; s_cnt = stall_cycles;
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic quiet();
      rst = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_jb = 0;
      icache_miss = 0; dcache_miss = 0; icache_done = 0; dcache_done = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1;
      cyc();
      chk("rst_stall",       32'(s_stall), 32'd0);
      chk("rst_jb",          32'(s_jb),    32'd0);
      chk("rst_stall_cache", 32'(s_sc),    32'd0);
      chk("rst_pc_write",    32'(s_pcw),   32'd1);
      rst = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       ld;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, jbi;
      logic       e_stall, e_jb, e_pcw;
   } vec_t;
   vec_t tv[9];

   initial begin
      tv[0] = '{1, 5'd5,  5'd5,  5'd0,  1, 0, 0, 1, 0, 0};
      tv[1] = '{1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, 0, 1};
      tv[2] = '{1, 5'd7,  5'd3,  5'd7,  1, 1, 0, 1, 0, 0};
      tv[3] = '{1, 5'd7,  5'd2,  5'd7,  1, 0, 0, 0, 0, 1};
      tv[4] = '{0, 5'd9,  5'd9,  5'd9,  1, 1, 0, 0, 0, 1};
      tv[5] = '{1, 5'd31, 5'd31, 5'd31, 0, 1, 0, 1, 0, 0};
      tv[6] = '{1, 5'd5,  5'd5,  5'd0,  1, 0, 1, 0, 1, 1};
      tv[7] = '{1, 5'd12, 5'd12, 5'd4,  0, 1, 0, 0, 0, 1};
      tv[8] = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 1, 1};

      quiet();
      rst = 1;
      repeat (2) @(posedge clk);
      #2;
      do_reset();
      chk("rst_stall_cycles", s_cnt, 32'd0);

      // combinational hazard vectors, no misses outstanding
      for (int i = 0; i < 9; i++) begin
         quiet();
         ex_is_load = tv[i].ld; ex_rd = tv[i].rd;
         id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2;
         id_use_rs1 = tv[i].u1; id_use_rs2 = tv[i].u2; ex_jb = tv[i].jbi;
         cyc();
         chk($sformatf("vec%0d_stall", i),    32'(s_stall), 32'(tv[i].e_stall));
         chk($sformatf("vec%0d_jb", i),       32'(s_jb),    32'(tv[i].e_jb));
         chk($sformatf("vec%0d_pc_write", i), 32'(s_pcw),   32'(tv[i].e_pcw));
      end

      // data miss: 4 miss cycles then done -> 5 held cycles
      do_reset();
      for (int i = 0; i < 5; i++) begin
         quiet();
         ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
         if (i < 4) dcache_miss = 1; else dcache_done = 1;
         cyc();
         chk($sformatf("dmiss_sc%0d", i), 32'(s_sc), 32'd1);
         chk($sformatf("dmiss_stall%0d", i), 32'(s_stall), 32'd0);
      end
      quiet();
      cyc();
      chk("dmiss_sc_after", 32'(s_sc), 32'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("dmiss_cycles", s_cnt, 32'd5);
`else
      chk("dmiss_cycles", s_cnt, 32'd0);
`endif

      // simultaneous misses: D first, then I, stray done pulses ignored
      do_reset();
      for (int i = 0; i < 8; i++) begin
         quiet();
         icache_miss = (i < 6);
         dcache_miss = (i < 3);
         dcache_done = (i == 3);
         icache_done = (i == 2) || (i == 6);
         cyc();
         chk($sformatf("both_sc%0d", i), 32'(s_sc), 32'(i < 7));
      end
      // a lone icache_done while data refill pending must not release
      do_reset();
      quiet(); dcache_miss = 1; cyc();
      quiet(); icache_done = 1; cyc();
      chk("stray_done_sc", 32'(s_sc), 32'd1);
      quiet(); cyc();
      chk("stray_done_hold", 32'(s_sc), 32'd1);
      quiet(); dcache_done = 1; cyc();
      quiet(); cyc();
      chk("stray_done_release", 32'(s_sc), 32'd0);

      // branch during miss: single flush after the hold
      do_reset();
      for (int i = 0; i < 7; i++) begin
         quiet();
         dcache_miss = (i < 4);
         dcache_done = (i == 4);
         ex_jb       = (i == 2);
         cyc();
         chk($sformatf("br_jb%0d", i), 32'(s_jb), 32'(i == 5));
         if (i == 5) chk("br_pc_write", 32'(s_pcw), 32'd1);
      end

      // reset mid-miss with pending flush
      do_reset();
      quiet(); icache_miss = 1; cyc();
      quiet(); icache_miss = 1; ex_jb = 1; cyc();
      quiet(); icache_miss = 1; rst = 1; cyc();
      chk("midrst_jb", 32'(s_jb), 32'd0);
      chk("midrst_sc", 32'(s_sc), 32'd0);
      quiet(); cyc();
      chk("postrst_jb", 32'(s_jb), 32'd0);
      chk("postrst_sc", 32'(s_sc), 32'd0);
      chk("postrst_cycles", s_cnt, 32'd0);

      // randomized traffic against the model
      quiet();
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 199) == 0);
         ex_is_load  = $urandom_range(0, 1);
         ex_rd       = 5'($urandom_range(0, 3));
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_use_rs1  = $urandom_range(0, 1);
         id_use_rs2  = $urandom_range(0, 1);
         ex_jb       = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) icache_miss = ~icache_miss;
         if ($urandom_range(0, 7) == 0) dcache_miss = ~dcache_miss;
         icache_done = ($urandom_range(0, 5) == 0);
         dcache_done = ($urandom_range(0, 5) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
